// File: rtl/display_scheduler.sv
// display_scheduler: shares a 3-digit multiplexed 7-segment display between a background and an overlay source.
module display_scheduler #(
  parameter int DIV  = 50000,
  parameter int HOLD = 200
) (
  input  logic       clock,
  input  logic       zera_s,
  input  logic [6:0] valor_a,
  input  logic       valida_a,
  input  logic [6:0] valor_b,
  input  logic       req_b,
  input  logic [1:0] brilho,
  output logic [6:0] numero,
  output logic [1:0] digito,
  output logic [3:0] anodo,
  output logic       overlay_ativo,
  output logic       frame_fim
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [31:0] DIV_U = DIV;
  localparam logic [0:0] MOSTRA_A = 1'b0;
  localparam logic [0:0] OVERLAY  = 1'b1;
  logic [PW-1:0] r_presc, w_presc_n;
  logic [6:0]    r_shadow_a, r_shadow_b, w_src, w_num_n;
  logic [HW-1:0] r_hold, w_hold_n;
  logic [0:0]    r_state, w_state_n;
  logic [1:0]    w_dig_n;
  logic [31:0]   w_thr;
  logic [3:0]    w_anodo_n;
  logic          w_tick, w_wrap, w_lit, w_en;
  assign overlay_ativo = (r_state == OVERLAY);
  always_comb begin
    w_tick    = (r_presc == PW'(DIV - 1));
    w_wrap    = w_tick && (digito == 2'd2);
    w_presc_n = w_tick ? '0 : r_presc + 1'b1;
    w_dig_n   = w_tick ? ((digito == 2'd2) ? 2'd0 : digito + 2'd1) : digito;
    w_src     = (r_state == OVERLAY) ? r_shadow_b : r_shadow_a;
    w_num_n   = w_wrap ? w_src : numero;
    w_thr     = ((32'(brilho) + 32'd1) * DIV_U) / 32'd4;
    w_lit     = 32'(w_presc_n) < w_thr;
    w_en      = (w_dig_n == 2'd2) ? (w_num_n >= 7'd100) : (w_dig_n == 2'd1) ? (w_num_n >= 7'd10) : 1'b1;
    // anode pattern is built from next-state slot/prescaler so the registered output lines up with them
    w_anodo_n = {1'b1, ~({2'b00, w_en && w_lit} << w_dig_n)};
    // a fresh request always reloads, even on the frame end where hold would have expired
    w_state_n = req_b ? OVERLAY : (r_state == OVERLAY && w_wrap && r_hold == HW'(1)) ? MOSTRA_A : r_state;
    w_hold_n  = req_b ? HW'(HOLD) : (r_state == OVERLAY && w_wrap) ? r_hold - 1'b1 : r_hold;
  end
  always_ff @(posedge clock) begin
    if (zera_s) begin
      r_presc    <= '0;
      digito     <= 2'd0;
      numero     <= 7'd0;
      r_shadow_a <= 7'd0;
      r_shadow_b <= 7'd0;
      r_hold     <= '0;
      r_state    <= MOSTRA_A;
      frame_fim  <= 1'b0;
      anodo      <= 4'b1111;
    end else begin
      r_presc    <= w_presc_n;
      digito     <= w_dig_n;
      numero     <= w_num_n;
      r_shadow_a <= valida_a ? valor_a : r_shadow_a;
      r_shadow_b <= req_b ? valor_b : r_shadow_b;
      r_hold     <= w_hold_n;
      r_state    <= w_state_n;
      frame_fim  <= w_wrap;
      anodo      <= w_anodo_n;
    end
  end
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed checks of scan timing, latching, blanking, overlay and brightness (DIV=4, HOLD=2).
module tb_display_scheduler;
  logic       clock = 1'b0;
  logic       zera_s = 1'b1;
  logic [6:0] valor_a = '0;
  logic       valida_a = 1'b0;
  logic [6:0] valor_b = '0;
  logic       req_b = 1'b0;
  logic [1:0] brilho = 2'd3;
  logic [6:0] numero;
  logic [1:0] digito;
  logic [3:0] anodo;
  logic       overlay_ativo;
  logic       frame_fim;
  int         vectors = 0;
  int         miscompares = 0;
  int         n;
  int         c0, c1, c2;

  display_scheduler #(.DIV(4), .HOLD(2)) dut (
    .clock(clock), .zera_s(zera_s), .valor_a(valor_a), .valida_a(valida_a),
    .valor_b(valor_b), .req_b(req_b), .brilho(brilho), .numero(numero),
    .digito(digito), .anodo(anodo), .overlay_ativo(overlay_ativo), .frame_fim(frame_fim)
  );

  always #5 clock = ~clock;

  task automatic step(input int k);
    repeat (k) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ff(output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (frame_fim !== 1'b1 && cnt < 100);
    chk("frame_fim_seen", 32'(frame_fim), 32'd1);
  endtask

  task automatic cap_a(input logic [6:0] v);
    valor_a = v;
    valida_a = 1'b1;
    step(1);
    valida_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [6:0] v);
    valor_b = v;
    req_b = 1'b1;
    step(1);
    req_b = 1'b0;
  endtask

  task automatic count_lit(output int s0, output int s1, output int s2);
    s0 = 0; s1 = 0; s2 = 0;
    for (int i = 0; i < 12; i++) begin
      if (anodo == 4'b1110) s0++;
      if (anodo == 4'b1101) s1++;
      if (anodo == 4'b1011) s2++;
      step(1);
    end
  endtask

  initial begin
    step(3);
    chk("rst_numero", 32'(numero), 32'd0);
    chk("rst_digito", 32'(digito), 32'd0);
    chk("rst_anodo", 32'(anodo), 32'hF);
    chk("rst_ovl", 32'(overlay_ativo), 32'd0);
    chk("rst_ff", 32'(frame_fim), 32'd0);
    zera_s = 1'b0;
    step(1);
    chk("scan_s0_anodo", 32'(anodo), 32'hE);
    step(3);
    chk("scan_s1_digito", 32'(digito), 32'd1);
    chk("scan_s1_blank", 32'(anodo), 32'hF);
    step(8);
    chk("scan_ff", 32'(frame_fim), 32'd1);
    chk("scan_wrap_digito", 32'(digito), 32'd0);
    chk("scan_wrap_anodo", 32'(anodo), 32'hE);
    step(1);
    chk("scan_ff_pulse", 32'(frame_fim), 32'd0);
    wait_ff(n);
    chk("frame_period", 32'(n + 1), 32'd12);

    cap_a(7'd123);
    chk("cap_no_tear", 32'(numero), 32'd0);
    wait_ff(n);
    chk("cap_numero", 32'(numero), 32'd123);
    chk("cap_s0", 32'(anodo), 32'hE);
    step(4);
    chk("cap_s1", 32'(anodo), 32'hD);
    step(4);
    chk("cap_s2", 32'(anodo), 32'hB);
    chk("cap_hold", 32'(numero), 32'd123);

    cap_a(7'd7);
    wait_ff(n);
    chk("blank7_numero", 32'(numero), 32'd7);
    chk("blank7_s0", 32'(anodo), 32'hE);
    step(4);
    chk("blank7_s1", 32'(anodo), 32'hF);
    step(4);
    chk("blank7_s2", 32'(anodo), 32'hF);
    cap_a(7'd45);
    wait_ff(n);
    chk("blank45_numero", 32'(numero), 32'd45);
    step(4);
    chk("blank45_s1", 32'(anodo), 32'hD);
    step(4);
    chk("blank45_s2", 32'(anodo), 32'hF);

    cap_a(7'd50);
    wait_ff(n);
    chk("ovl_bg", 32'(numero), 32'd50);
    pulse_b(7'd99);
    chk("ovl_active", 32'(overlay_ativo), 32'd1);
    chk("ovl_no_tear", 32'(numero), 32'd50);
    wait_ff(n);
    chk("ovl_numero", 32'(numero), 32'd99);
    chk("ovl_still", 32'(overlay_ativo), 32'd1);
    wait_ff(n);
    chk("ovl_expire", 32'(overlay_ativo), 32'd0);
    wait_ff(n);
    chk("ovl_back_numero", 32'(numero), 32'd50);
    chk("ovl_back_flag", 32'(overlay_ativo), 32'd0);

    pulse_b(7'd99);
    wait_ff(n);
    step(11);
    valor_b = 7'd60;
    req_b = 1'b1;
    step(1);
    req_b = 1'b0;
    chk("race_ff", 32'(frame_fim), 32'd1);
    chk("race_ovl", 32'(overlay_ativo), 32'd1);
    wait_ff(n);
    chk("race_n1", 32'(numero), 32'd60);
    chk("race_ovl1", 32'(overlay_ativo), 32'd1);
    wait_ff(n);
    chk("race_n2", 32'(numero), 32'd60);
    wait_ff(n);
    chk("race_back", 32'(numero), 32'd50);
    chk("race_ovl_off", 32'(overlay_ativo), 32'd0);

    brilho = 2'd1;
    wait_ff(n);
    count_lit(c0, c1, c2);
    chk("pwm1_s0", 32'(c0), 32'd2);
    chk("pwm1_s1", 32'(c1), 32'd2);
    chk("pwm1_s2", 32'(c2), 32'd0);
    brilho = 2'd0;
    wait_ff(n);
    count_lit(c0, c1, c2);
    chk("pwm0_s0", 32'(c0), 32'd1);
    chk("pwm0_s1", 32'(c1), 32'd1);

    pulse_b(7'd77);
    chk("mid_ovl", 32'(overlay_ativo), 32'd1);
    step(5);
    zera_s = 1'b1;
    step(1);
    zera_s = 1'b0;
    chk("mid_rst_anodo", 32'(anodo), 32'hF);
    chk("mid_rst_digito", 32'(digito), 32'd0);
    chk("mid_rst_ovl", 32'(overlay_ativo), 32'd0);
    chk("mid_rst_numero", 32'(numero), 32'd0);
    wait_ff(n);
    chk("mid_rst_shadow", 32'(numero), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
